// File: rtl/mux4_rr_arbiter.sv
// Round-robin, packet-holding arbiter driving the select of a shared 4:1 data mux.
// Define ARB_WATCHDOG_EN to add a hold-cycle watchdog that forces a grant release after MAX_HOLD cycles.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_last,
    output logic [3:0]         in_ready,
    output logic [1:0]         sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic       last_xfer;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must lie in 2..255");
    end

    // Search starts just after the previous winner; ptr itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 4; i >= 1; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign last_xfer = (state_q == GRANT) && req[sel_q] && out_ready && in_last[sel_q];

`ifdef ARB_WATCHDOG_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = 8'd0;
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(req, ptr_q);
                end
            end
            GRANT: begin
                hold_d = hold_q + 8'd1;
                // A last beat landing on the limit cycle still exits normally.
                if (last_xfer) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                end else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    ptr_d     = sel_q;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(req, ptr_q);
                end
            end
            GRANT: begin
                if (last_xfer) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // Datapath and handshakes are routed combinationally while a grant is held.
    always_comb begin
        in_ready  = 4'b0000;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (state_q == GRANT) begin
            busy            = 1'b1;
            out_valid       = req[sel_q];
            out_data        = in_data[sel_q*WIDTH +: WIDTH];
            out_last        = in_last[sel_q];
            in_ready[sel_q] = out_ready;
        end
    end

    assign sel = sel_q;

endmodule
